rf_wb_arbiter: RTL

Shares the register file's single write port between two write-back requesters: channel A (ALU/EX result) and channel B (load/MEM result). Uses round-robin arbitration with valid/ready handshakes and a one-entry registered output stage that drives the register file write port. Drops writes to x0 and counts them. Sits between the EX/MEM write-back paths and register_file.

---
 rtl/rf_wb_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between EX (A) and MEM (B) write-back; x0 writes are acked, dropped and counted.
// Latency: one cycle from accept to rf_write_en; one write per cycle sustained.
// Backpressure: rf_stall holds the registered entry and blocks new grants; RF_WB_BYPASS_EN adds pending-write forwarding ports.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ADDR_WIDTH-1:0]     a_rd_addr,
    input  logic [DATA_WIDTH-1:0]     a_rd_data,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [ADDR_WIDTH-1:0]     b_rd_addr,
    input  logic [DATA_WIDTH-1:0]     b_rd_data,
    input  logic                      rf_stall,
    output logic                      rf_write_en,
    output logic [ADDR_WIDTH-1:0]     rf_rd_addr,
    output logic [DATA_WIDTH-1:0]     rf_data_in,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0]     byp_rs1_addr,
    input  logic [ADDR_WIDTH-1:0]     byp_rs2_addr,
    output logic                      byp_rs1_hit,
    output logic                      byp_rs2_hit,
    output logic [DATA_WIDTH-1:0]     byp_data
`endif
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
    } wb_ent_t;

    logic                      out_vld_q, out_vld_d;
    wb_ent_t                   out_ent_q, out_ent_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      rr_last_q, rr_last_d;  // 1 = B won last, so A wins the next tie
    logic                      can_accept;
    logic                      gnt_a, gnt_b;
    wb_ent_t                   req_ent;

    always_comb begin
        can_accept = ~out_vld_q | ~rf_stall;
        gnt_a      = can_accept & a_valid & (~b_valid | rr_last_q);
        gnt_b      = can_accept & b_valid & (~a_valid | ~rr_last_q);
        req_ent.addr = gnt_b ? b_rd_addr : a_rd_addr;
        req_ent.dat  = gnt_b ? b_rd_data : a_rd_data;
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_ent_d  = out_ent_q;
        drop_cnt_d = drop_cnt_q;
        rr_last_d  = rr_last_q;
        if (gnt_a | gnt_b) begin
            rr_last_d = gnt_b;
            if (req_ent.addr == '0) begin
                out_vld_d = 1'b0;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
                end
            end else begin
                out_vld_d = 1'b1;
                out_ent_d = req_ent;
            end
        end else if (can_accept) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_ent_q  <= '0;
            drop_cnt_q <= '0;
            rr_last_q  <= 1'b1;
        end else begin
            out_vld_q  <= out_vld_d;
            out_ent_q  <= out_ent_d;
            drop_cnt_q <= drop_cnt_d;
            rr_last_q  <= rr_last_d;
        end
    end

    assign a_ready     = gnt_a;
    assign b_ready     = gnt_b;
    assign rf_write_en = out_vld_q & ~rf_stall;
    assign rf_rd_addr  = out_ent_q.addr;
    assign rf_data_in  = out_ent_q.dat;
    assign drop_count  = drop_cnt_q;

`ifdef RF_WB_BYPASS_EN
    // Forward the pending entry to decode, including while the RF is stalled.
    assign byp_rs1_hit = out_vld_q & (out_ent_q.addr == byp_rs1_addr) & (byp_rs1_addr != '0);
    assign byp_rs2_hit = out_vld_q & (out_ent_q.addr == byp_rs2_addr) & (byp_rs2_addr != '0);
    assign byp_data    = out_ent_q.dat;
`endif

endmodule
